// File: rtl/qc_ldpc_pkg.sv
// Shared definitions for the QC-LDPC encoder and decoder control paths:
// code constants, counter widths and the sweep sequencer state encoding.
package qc_ldpc_pkg;

  localparam int CIRC_B        = 87;  // circulant size b
  localparam int N_COL_BLOCKS  = 40;  // column blocks per codeword
  localparam int N_INFO_BLOCKS = 24;  // information blocks per codeword
  localparam int DEF_MAX_ITER  = 8;   // default flip iteration limit

  localparam int BIT_W  = 7;          // holds 0..b-1
  localparam int BLK_W  = 6;          // holds 0..N_COL_BLOCKS-1
  localparam int ITER_W = 4;          // holds 0..15

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CLR   = 4'd1,
    SLOAD = 4'd2,
    SACC  = 4'd3,
    CHECK = 4'd4,
    FLOAD = 4'd5,
    FLIP  = 4'd6,
    WB    = 4'd7,
    DONE  = 4'd8
  } state_t;

endpackage

// File: rtl/qc_ldpc_decoder_control_path_if.sv
// Handshake and datapath-strobe bundle between the decoder control path
// (slave side) and whoever starts it and hosts the datapath (master side).
interface qc_ldpc_decoder_control_path_if;
  import qc_ldpc_pkg::*;

  logic              start;
  logic              syndrome_zero;
  logic              clear_syndrome;
  logic              load_cw_block;
  logic              acc_en;
  logic              flip_en;
  logic              writeback;
  logic [BLK_W-1:0]  block_idx;
  logic [BIT_W-1:0]  bit_idx;
  logic [ITER_W-1:0] iter_count;
  logic              busy;
  logic              done;
  logic              decode_ok;

  modport master (
    output start, syndrome_zero,
    input  clear_syndrome, load_cw_block, acc_en, flip_en, writeback,
           block_idx, bit_idx, iter_count, busy, done, decode_ok
  );

  modport slave (
    input  start, syndrome_zero,
    output clear_syndrome, load_cw_block, acc_en, flip_en, writeback,
           block_idx, bit_idx, iter_count, busy, done, decode_ok
  );

endinterface

// File: rtl/qc_ldpc_block_counter.sv
// Nested bit-within-circulant / column-block counter. Both counters hold at
// their terminal values; blk_step advances the block and rewinds the bit.
module qc_ldpc_block_counter
  import qc_ldpc_pkg::*;
#(
  parameter int BIT_MAX = CIRC_B - 1,
  parameter int BLK_MAX = N_COL_BLOCKS - 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             blk_step,
  output logic [BIT_W-1:0] bit_idx,
  output logic [BLK_W-1:0] block_idx,
  output logic             bit_last,
  output logic             blk_last
);

  localparam logic [BIT_W-1:0] BIT_TERM = BIT_W'(BIT_MAX);
  localparam logic [BLK_W-1:0] BLK_TERM = BLK_W'(BLK_MAX);

  assign bit_last = (bit_idx == BIT_TERM);
  assign blk_last = (block_idx == BLK_TERM);

  // Counter registers: clear has priority, then block step, then bit step.
  // NOTE: flops use non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx   <= '0;
      block_idx <= '0;
    end else if (clear) begin
      bit_idx   <= '0;
      block_idx <= '0;
    end else if (blk_step) begin
      bit_idx <= '0;
      if (!blk_last) block_idx <= block_idx + 1'b1;
    end else if (bit_en && !bit_last) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

endmodule

// File: rtl/qc_ldpc_decoder_control_path.sv
// Bit-flipping decoder sequencer: alternates a syndrome sweep with a flip
// sweep over all column blocks until the syndrome is zero or the iteration
// limit is reached. Datapath strobes are pure decodes of the state.
module qc_ldpc_decoder_control_path
  import qc_ldpc_pkg::*;
#(
  parameter int CIRC_SIZE      = CIRC_B,
  parameter int NUM_COL_BLOCKS = N_COL_BLOCKS,
  parameter int MAX_ITER       = DEF_MAX_ITER
) (
  input logic                            clk,
  input logic                            reset_n,
  qc_ldpc_decoder_control_path_if.slave  bus
);

  localparam logic [ITER_W-1:0] ITER_TERM = ITER_W'(MAX_ITER);

  state_t            state, state_next;
  logic              cnt_clear, cnt_bit_en, cnt_blk_step;
  logic              bit_last, blk_last;
  logic              new_decode;
  logic [ITER_W-1:0] iter_count;
  logic              decode_ok;
  logic              start_ok;

  assign start_ok = ((state == IDLE) || (state == DONE)) && bus.start;

  qc_ldpc_block_counter #(
    .BIT_MAX (CIRC_SIZE - 1),
    .BLK_MAX (NUM_COL_BLOCKS - 1)
  ) u_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (cnt_clear),
    .bit_en    (cnt_bit_en),
    .blk_step  (cnt_blk_step),
    .bit_idx   (bus.bit_idx),
    .block_idx (bus.block_idx),
    .bit_last  (bit_last),
    .blk_last  (blk_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state, Moore strobes and counter controls.
  // NOTE: every output gets a default before the case, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next         = state;
    bus.clear_syndrome = 1'b0;
    bus.load_cw_block  = 1'b0;
    bus.acc_en         = 1'b0;
    bus.flip_en        = 1'b0;
    bus.writeback      = 1'b0;
    bus.busy           = 1'b0;
    bus.done           = 1'b0;
    cnt_clear          = 1'b0;
    cnt_bit_en         = 1'b0;
    cnt_blk_step       = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = CLR;
      CLR: begin
        bus.clear_syndrome = 1'b1;
        bus.busy           = 1'b1;
        cnt_clear          = 1'b1;
        state_next         = SLOAD;
      end
      SLOAD: begin
        bus.load_cw_block = 1'b1;
        bus.busy          = 1'b1;
        state_next        = SACC;
      end
      SACC: begin
        bus.acc_en = 1'b1;
        bus.busy   = 1'b1;
        if (!bit_last) begin
          cnt_bit_en = 1'b1;
        end else if (blk_last) begin
          state_next = CHECK;
        end else begin
          cnt_blk_step = 1'b1;
          state_next   = SLOAD;
        end
      end
      CHECK: begin
        bus.busy = 1'b1;
        if (bus.syndrome_zero || (iter_count == ITER_TERM)) begin
          state_next = DONE;
        end else begin
          cnt_clear  = 1'b1;
          state_next = FLOAD;
        end
      end
      FLOAD: begin
        bus.load_cw_block = 1'b1;
        bus.busy          = 1'b1;
        state_next        = FLIP;
      end
      FLIP: begin
        bus.flip_en = 1'b1;
        bus.busy    = 1'b1;
        if (bit_last) state_next = WB;
        else          cnt_bit_en = 1'b1;
      end
      WB: begin
        bus.writeback = 1'b1;
        bus.busy      = 1'b1;
        if (blk_last) begin
          state_next = CLR;
        end else begin
          cnt_blk_step = 1'b1;
          state_next   = FLOAD;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) state_next = CLR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Iteration count, convergence flag and first-CLR-of-decode marker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iter_count <= '0;
      decode_ok  <= 1'b0;
      new_decode <= 1'b0;
    end else begin
      if (start_ok) new_decode <= 1'b1;
      case (state)
        CLR: if (new_decode) begin
          iter_count <= '0;
          decode_ok  <= 1'b0;
          new_decode <= 1'b0;
        end
        CHECK: decode_ok <= bus.syndrome_zero;
        WB: if (blk_last && (iter_count != ITER_TERM)) iter_count <= iter_count + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.iter_count = iter_count;
  assign bus.decode_ok  = decode_ok;

endmodule

// File: tb/tb_qc_ldpc_decoder_control_path.sv
// Bench for the decoder control path: randomized start/syndrome_zero noise
// checked against a sweep-level timing and pulse-count model.
module tb_qc_ldpc_decoder_control_path;
  import qc_ldpc_pkg::*;

  localparam int B       = 87;
  localparam int NB      = 40;
  localparam int MAX_IT  = 8;
  localparam int SWEEP   = 1 + NB * (1 + B) + 1;   // CLR + blocks + CHECK
  localparam int FSWEEP  = NB * (B + 2);           // FLOAD + FLIP + WB per block
  localparam int PERIOD  = SWEEP + FSWEEP;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  qc_ldpc_decoder_control_path_if bus ();
  qc_ldpc_decoder_control_path_if bus0 ();

  qc_ldpc_decoder_control_path #(
    .CIRC_SIZE (B), .NUM_COL_BLOCKS (NB), .MAX_ITER (MAX_IT)
  ) dut (
    .clk (clk), .reset_n (reset_n), .bus (bus)
  );

  qc_ldpc_decoder_control_path #(
    .CIRC_SIZE (B), .NUM_COL_BLOCKS (NB), .MAX_ITER (0)
  ) dut_mi0 (
    .clk (clk), .reset_n (reset_n), .bus (bus0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] outs(input int which);
    if (which == 0)
      return {7'b0, bus.clear_syndrome, bus.load_cw_block, bus.acc_en, bus.flip_en,
              bus.writeback, bus.block_idx, bus.bit_idx, bus.iter_count,
              bus.busy, bus.done, bus.decode_ok};
    else
      return {7'b0, bus0.clear_syndrome, bus0.load_cw_block, bus0.acc_en, bus0.flip_en,
              bus0.writeback, bus0.block_idx, bus0.bit_idx, bus0.iter_count,
              bus0.busy, bus0.done, bus0.decode_ok};
  endfunction

  // One full decode on the MAX_ITER=8 instance. conv is the index of the
  // CHECK at which the syndrome reads zero (large value = never converges).
  task automatic run_decode(input int conv, input string tag);
    int   k, lat, done_at, prev_bit, prev_blk;
    int   n_wb, n_ld, n_clr, n_fl, n_wrap, n_rng, n_phase;
    logic ok;
    k   = (conv <= MAX_IT) ? conv : MAX_IT;
    ok  = (conv <= MAX_IT);
    lat = SWEEP + k * PERIOD;
    done_at = -1; prev_bit = -1; prev_blk = -1;
    n_wb = 0; n_ld = 0; n_clr = 0; n_fl = 0; n_wrap = 0; n_rng = 0; n_phase = 0;
    for (int s = 0; s <= lat; s++) begin
      // inputs for edge s; start only matters at s=0, later pulses hit busy states
      bus.start = (s == 0) ? 1'b1 : ($urandom_range(0, 63) == 0);
      if (s >= SWEEP && ((s - SWEEP) % PERIOD) == 0)
        bus.syndrome_zero = (((s - SWEEP) / PERIOD) == conv);
      else
        bus.syndrome_zero = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (bus.done && done_at < 0) done_at = s;
      if (s < lat && (bus.busy !== 1'b1 || bus.done !== 1'b0)) n_phase++;
      n_wb  += int'(bus.writeback);
      n_ld  += int'(bus.load_cw_block);
      n_clr += int'(bus.clear_syndrome);
      n_fl  += int'(bus.flip_en);
      if (int'(bus.bit_idx) == 0 && prev_bit == B - 1 && int'(bus.block_idx) == prev_blk + 1)
        n_wrap++;
      if (int'(bus.bit_idx) > B - 1 || int'(bus.block_idx) > NB - 1 || int'(bus.iter_count) > MAX_IT)
        n_rng++;
      prev_bit = int'(bus.bit_idx);
      prev_blk = int'(bus.block_idx);
      if (done_at >= 0) break;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, done_at, lat);
    check({tag, "_decode_ok"}, {31'b0, bus.decode_ok}, {31'b0, ok});
    check({tag, "_iter_count"}, {28'b0, bus.iter_count}, k);
    check({tag, "_writebacks"}, n_wb, NB * k);
    check({tag, "_loads"}, n_ld, NB * (2 * k + 1));
    check({tag, "_clears"}, n_clr, k + 1);
    check({tag, "_flips"}, n_fl, B * NB * k);
    check({tag, "_bit_wraps"}, n_wrap, (NB - 1) * (2 * k + 1));
    check({tag, "_range_errs"}, n_rng, 0);
    check({tag, "_busy_phase_errs"}, n_phase, 0);
  endtask

  // MAX_ITER=0 instance: syndrome-only decode, then restart by holding start in DONE.
  task automatic run_mi0();
    int n, n_fl;
    bus0.syndrome_zero = 1'b0;
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    n = 0; n_fl = 0;
    while (!bus0.done && n < SWEEP + 100) begin
      @(posedge clk); #1;
      n++;
      n_fl += int'(bus0.flip_en);
    end
    check("mi0_latency", n, SWEEP);
    check("mi0_decode_ok", {31'b0, bus0.decode_ok}, 0);
    check("mi0_iter_count", {28'b0, bus0.iter_count}, 0);
    check("mi0_flips", n_fl, 0);
    bus0.start = 1'b1;
    @(posedge clk); #1;
    check("mi0_restart_done", {31'b0, bus0.done}, 0);
    check("mi0_restart_clear", {31'b0, bus0.clear_syndrome}, 1);
    bus0.start = 1'b0;
    bus0.syndrome_zero = 1'b1;
    n = 0;
    while (!bus0.done && n < SWEEP + 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mi0_relatency", n, SWEEP);
    check("mi0_reok", {31'b0, bus0.decode_ok}, 1);
  endtask

  initial begin
    int   found;
    logic wb_seen;
    bus.start = 1'b0;  bus.syndrome_zero = 1'b0;
    bus0.start = 1'b0; bus0.syndrome_zero = 1'b0;
    #12;
    check("reset_outs", outs(0), 0);
    check("reset_outs_mi0", outs(1), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outs", outs(0), 0);

    // converges at the second CHECK, random start pulses while busy
    run_decode(1, "conv1");

    // never converges, in parallel with the MAX_ITER=0 instance
    fork
      run_decode(1000, "maxit");
      run_mi0();
    join

    // abort during FLIP of block 17
    bus.syndrome_zero = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < SWEEP + 20 * (B + 2); i++) begin
      @(posedge clk); #1;
      if (bus.flip_en && int'(bus.block_idx) == 17 && int'(bus.bit_idx) == 40) begin
        found = 1;
        break;
      end
    end
    check("rst_reach_flip17", found, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_async_outs", outs(0), 0);
    wb_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      wb_seen |= bus.writeback;
    end
    check("rst_no_writeback", {31'b0, wb_seen}, 0);
    check("rst_hold_outs", outs(0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // fresh decode after reset, syndrome zero at the first CHECK
    run_decode(0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
